adsr_envelope: RTL and testbench

Per-voice ADSR envelope generator for the tracker synth voice. It converts a note gate into a 6-bit amplitude that drives the `vol` input of the DDS sine stage directly downstream. The generator advances on a divided envelope tick and holds all state in one clock domain. It produces no audio itself; its output scales the sine output by vol/64.

---
 rtl/adsr_envelope.sv | 86 ++++++++
 tb/tb_adsr_envelope.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven ADSR amplitude generator; clk/rst_active_high in, gate + rates + sustain_level in, vol/stage/busy out; ADSR_LEGATO_EN keeps level on retrigger from RELEASE
module adsr_envelope #(
  parameter int TICK_DIV   = 1024,
  parameter int RATE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_active_high,
  input  logic                  gate,
  input  logic [RATE_WIDTH-1:0] attack_rate,
  input  logic [RATE_WIDTH-1:0] decay_rate,
  input  logic [5:0]            sustain_level,
  input  logic [RATE_WIDTH-1:0] release_rate,
  output logic [5:0]            vol,
  output logic [2:0]            stage,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4} state_t;
  localparam logic [14:0] MAX = 15'h3f00;
  localparam int CW = $clog2(TICK_DIV);
  state_t state, state_n;
  logic [13:0] level, level_n;
  logic [CW-1:0] cnt;
  logic gate_q, rise, fall, tick;
  logic [14:0] ar, dr, rr, sus, up, dec_floor;
  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;
  assign tick = cnt == CW'(TICK_DIV - 1);
  assign ar = 15'(attack_rate);
  assign dr = 15'(decay_rate);
  assign rr = 15'(release_rate);
  assign sus = {1'b0, sustain_level, 8'h00};
  // one spare bit so the attack sum and decay floor cannot wrap
  assign up = {1'b0, level} + ar;
  assign dec_floor = sus + dr;
  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      state  <= IDLE;
      level  <= '0;
      gate_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      gate_q <= gate;
      cnt    <= tick ? '0 : cnt + CW'(1);
    end
  end
  always_comb begin
    state_n = state;
    level_n = level;
    if (rise && (state == IDLE || state == RELEASE)) begin
      state_n = ATTACK;
`ifdef ADSR_LEGATO_EN
      level_n = level;
`else
      level_n = '0;
`endif
    end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_n = RELEASE;
    end else begin
      case (state)
        ATTACK: if (tick) begin
          state_n = (up >= MAX || ar == '0) ? DECAY : ATTACK;
          level_n = (up >= MAX || ar == '0) ? MAX[13:0] : up[13:0];
        end
        DECAY: if (tick) begin
          state_n = ({1'b0, level} <= dec_floor || dr == '0) ? SUSTAIN : DECAY;
          level_n = ({1'b0, level} <= dec_floor || dr == '0) ? sus[13:0] : level - dr[13:0];
        end
        SUSTAIN: level_n = sus[13:0];
        RELEASE: if (tick) begin
          state_n = ({1'b0, level} <= rr || rr == '0) ? IDLE : RELEASE;
          level_n = ({1'b0, level} <= rr || rr == '0) ? '0 : level - rr[13:0];
        end
        IDLE: level_n = '0;
        default: begin
          state_n = IDLE;
          level_n = '0;
        end
      endcase
    end
  end
  assign vol = level[13:8];
  assign stage = state;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: table-driven envelope runs plus reset, sustain tracking, retrigger and edge/tick collision sequences
module tb_adsr_envelope;
  logic clk = 1'b0, rst = 1'b1, gate = 1'b0;
  logic [8:0] ar = '0, dr = '0, rr = '0;
  logic [5:0] sl = '0;
  logic [5:0] vol;
  logic [2:0] stage;
  logic busy;
  always #5 clk = ~clk;
  adsr_envelope #(.TICK_DIV(4), .RATE_WIDTH(9)) dut (
    .clk(clk), .rst_active_high(rst), .gate(gate), .attack_rate(ar), .decay_rate(dr),
    .sustain_level(sl), .release_rate(rr), .vol(vol), .stage(stage), .busy(busy)
  );
  typedef struct {string nm; int v;} exp_t;
  typedef struct {logic [8:0] ar; logic [8:0] dr; logic [5:0] sl; logic [8:0] rr; int at; int dt; int rt;} vec_t;
  exp_t sb[$];
  vec_t vecs[6];
  int checks = 0, errors = 0, phase = 0;
  bit tick_seen = 1'b0;
  function automatic void expect_v(string nm, int v);
    exp_t e;
    e.nm = nm;
    e.v = v;
    sb.push_back(e);
  endfunction
  task automatic chk(input int act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=%0d", act);
      return;
    end
    e = sb.pop_front();
    if (act != e.v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", e.nm, act, e.v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    tick_seen = !rst && phase == 3;
    phase = rst ? 0 : (phase + 1) % 4;
    @(negedge clk);
  endtask
  task automatic wait_stage(input int tgt, output int ticks);
    ticks = 0;
    for (int i = 0; i < 20000; i++) begin
      step();
      if (tick_seen) ticks++;
      if (int'(stage) == tgt) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_stage_%0d actual_stage=%0d", tgt, stage);
  endtask
  initial begin
    int t, n;
    vecs[0] = '{9'h080, 9'h080, 6'd32, 9'h100, 126, 62, 32};
    vecs[1] = '{9'h000, 9'h000, 6'd10, 9'h000, 1, 1, 1};
    vecs[2] = '{9'h0ff, 9'h040, 6'd0, 9'h0ff, 64, 252, 1};
    vecs[3] = '{9'h040, 9'h0ff, 6'd63, 9'h010, 252, 1, 1008};
    vecs[4] = '{9'h07f, 9'h000, 6'd5, 9'h007, 127, 1, 183};
    vecs[5] = '{9'h1ff, 9'h155, 6'd20, 9'h1ff, 32, 33, 11};
    rst = 1'b1;
    gate = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_v("rst_vol", 0);
      expect_v("rst_stage", 0);
      expect_v("rst_busy", 0);
      step();
      chk(vol);
      chk(stage);
      chk(busy);
    end
    rst = 1'b0;
    expect_v("rise_after_rst", 1);
    step();
    chk(stage);
    rst = 1'b1;
    gate = 1'b0;
    step();
    step();
    rst = 1'b0;
    foreach (vecs[k]) begin
      ar = vecs[k].ar;
      dr = vecs[k].dr;
      sl = vecs[k].sl;
      rr = vecs[k].rr;
      gate = 1'b1;
      expect_v("attack_enter", 1);
      expect_v("attack_busy", 1);
      step();
      chk(stage);
      chk(busy);
      expect_v("attack_ticks", vecs[k].at);
      expect_v("peak_vol", 63);
      wait_stage(2, t);
      chk(t);
      chk(vol);
      expect_v("decay_ticks", vecs[k].dt);
      expect_v("sustain_vol", vecs[k].sl);
      wait_stage(3, t);
      chk(t);
      chk(vol);
      gate = 1'b0;
      expect_v("release_enter", 4);
      step();
      chk(stage);
      expect_v("release_ticks", vecs[k].rt);
      expect_v("idle_vol", 0);
      expect_v("idle_busy", 0);
      wait_stage(0, t);
      chk(t);
      chk(vol);
      chk(busy);
    end
    ar = '0;
    dr = '0;
    sl = 6'd32;
    rr = 9'h100;
    gate = 1'b1;
    expect_v("track_start_vol", 32);
    wait_stage(3, t);
    chk(vol);
    sl = 6'd50;
    expect_v("track_vol", 50);
    expect_v("track_stage", 3);
    step();
    chk(vol);
    chk(stage);
    sl = 6'd32;
    expect_v("track_back_vol", 32);
    step();
    chk(vol);
    gate = 1'b0;
    expect_v("retrig_release", 4);
    step();
    chk(stage);
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      step();
      if (tick_seen) n++;
    end
    expect_v("retrig_pre_vol", 24);
    expect_v("retrig_pre_stage", 4);
    chk(vol);
    chk(stage);
    dr = 9'h100;
    sl = 6'd0;
    gate = 1'b1;
    expect_v("retrig_stage", 1);
`ifdef ADSR_LEGATO_EN
    expect_v("retrig_vol", 24);
`else
    expect_v("retrig_vol", 0);
`endif
    step();
    chk(stage);
    chk(vol);
    expect_v("retrig_peak_ticks", 1);
    expect_v("retrig_peak_vol", 63);
    wait_stage(2, t);
    chk(t);
    chk(vol);
    n = 0;
    for (int i = 0; i < 8 && phase != 3; i++) begin
      step();
      if (tick_seen) n++;
    end
    gate = 1'b0;
    expect_v("collide_stage", 4);
    expect_v("collide_vol", 63 - n);
    step();
    chk(stage);
    chk(vol);
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick_seen) break;
    end
    expect_v("post_collide_vol", 62 - n);
    chk(vol);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
